// File: rtl/classifier_frame_scheduler.sv
// Ping-pong pixel frame buffer feeding the classifier RAM port, with input_valid
// flag handshake and a tag FIFO that labels each prediction with its frame number.
module classifier_frame_scheduler #(
    parameter int PIXELS    = 784,
    parameter int ADDR_W    = 10,
    parameter int TAG_W     = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pixel_data,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    output logic [7:0]        classifier_input_valid_read_data,
    input  logic              classifier_input_valid_write_en,
    input  logic [7:0]        classifier_input_valid_write_data,
    input  logic [ADDR_W-1:0] classifier_input_address_a,
    output logic [15:0]       classifier_input_read_data_a,
    input  logic [3:0]        classifier_output,
    input  logic              classifier_output_valid,
    output logic              classifier_output_ready,
    output logic [3:0]        result_data,
    output logic [TAG_W-1:0]  result_tag,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [TAG_W-1:0]  frames_loaded,
    output logic              protocol_error
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_e;

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] PIX_LIMIT  = ADDR_W'(PIXELS);
    localparam logic [PTR_W:0]    FIFO_LIMIT = (PTR_W + 1)'(TAG_DEPTH);

    bank_state_e        state_q [2];
    bank_state_e        state_d [2];
    logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;
    logic [TAG_W-1:0]   tags_q [TAG_DEPTH];
    logic [TAG_W-1:0]   tags_d [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     fifo_cnt_q, fifo_cnt_d;
    logic [TAG_W-1:0]   frames_q, frames_d;
    logic               err_q, err_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic [7:0]         mem [2][PIXELS];

    logic fifo_full, fifo_empty, input_valid, pix_fire, release_ok, release_bad, pop;
    logic unused_wdata;

    assign unused_wdata = ^classifier_input_valid_write_data[7:1];

    assign fifo_full   = (fifo_cnt_q == FIFO_LIMIT);
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign input_valid = (state_q[rd_bank_q] == FULL) && !fifo_full;
    assign pixel_ready = !reset && (state_q[wr_bank_q] != FULL);
    assign pix_fire    = pixel_valid && pixel_ready;
    assign release_ok  = classifier_input_valid_write_en && !classifier_input_valid_write_data[0]
                         && input_valid;
    assign release_bad = classifier_input_valid_write_en && !classifier_input_valid_write_data[0]
                         && !input_valid;
    assign pop         = classifier_output_valid && classifier_output_ready;

    assign classifier_input_valid_read_data = {7'b0, input_valid};
    assign classifier_input_read_data_a     = rd_data_q;
    assign classifier_output_ready          = result_ready && !fifo_empty;
    assign result_valid                     = classifier_output_valid && !fifo_empty;
    assign result_data                      = classifier_output;
    assign result_tag                       = tags_q[rd_ptr_q];
    assign frames_loaded                    = frames_q;
    assign protocol_error                   = err_q;

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        cnt_d      = cnt_q;
        tag_cnt_d  = tag_cnt_q;
        tags_d     = tags_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        frames_d   = frames_q;
        err_d      = err_q | release_bad | (classifier_output_valid && fifo_empty);
        rd_data_d  = 16'h0000;

        if (classifier_input_address_a < PIX_LIMIT)
            rd_data_d = {8'h00, mem[rd_bank_q][classifier_input_address_a]};

        if (pix_fire) begin
            cnt_d = cnt_q + 1'b1;
            if (state_q[wr_bank_q] == EMPTY) state_d[wr_bank_q] = FILLING;
            if (cnt_q == LAST_PIX) begin
                state_d[wr_bank_q] = FULL;
                cnt_d              = '0;
                wr_bank_d          = ~wr_bank_q;
                frames_d           = frames_q + 1'b1;
            end
        end

        // A release always targets the other bank from any fill in progress.
        if (release_ok) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
            tags_d[wr_ptr_q]   = tag_cnt_q;
            wr_ptr_d           = wr_ptr_q + 1'b1;
            tag_cnt_d          = tag_cnt_q + 1'b1;
        end

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        if (release_ok && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!release_ok && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '{EMPTY, EMPTY};
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            cnt_q      <= '0;
            tag_cnt_q  <= '0;
            tags_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            frames_q   <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            cnt_q      <= cnt_d;
            tag_cnt_q  <= tag_cnt_d;
            tags_q     <= tags_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            frames_q   <= frames_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Frame storage is never cleared; pixel_ready is low in reset so no write lands then.
    always_ff @(posedge clk) begin
        if (pix_fire) mem[wr_bank_q][cnt_q] <= pixel_data;
    end
endmodule

// File: doc/classifier_frame_scheduler.md
Name: classifier_frame_scheduler

Overview:
- Ping-pong frame buffer and handshake controller in front of the ClassifierPipeline accelerator.
- Accepts a byte-wide pixel stream and fills one 784-pixel bank while the classifier reads the other through its RAM port.
- Drives the classifier's input_valid flag protocol.
- Tags each 4-bit prediction with the sequence number of the frame that produced it.

Parameters:
PIXELS, 784, pixels per frame (28x28)
ADDR_W, 10, classifier input address width
TAG_W, 16, frame sequence tag width
TAG_DEPTH, 4, tag FIFO depth (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pixel_data  in  8  incoming pixel
pixel_valid  in  1  pixel present
pixel_ready  out  1  scheduler accepts pixel
classifier_input_valid_read_data  out  8  {7'b0, input_valid} to classifier
classifier_input_valid_write_en  in  1  classifier writes input_valid flag
classifier_input_valid_write_data  in  8  flag value written
classifier_input_address_a  in  ADDR_W  classifier pixel read address
classifier_input_read_data_a  out  16  {8'b0, pixel}, 1-cycle latency
classifier_output  in  4  prediction from classifier
classifier_output_valid  in  1  prediction valid
classifier_output_ready  out  1  scheduler accepts prediction
result_data  out  4  prediction
result_tag  out  TAG_W  frame sequence number of prediction
result_valid  out  1  result present
result_ready  in  1  downstream accepts result
frames_loaded  out  TAG_W  count of completed bank fills
protocol_error  out  1  sticky error flag

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; when reset is high at a rising edge, all state clears.
- Reset values:
  - both banks EMPTY; wr_bank = 0, rd_bank = 0; pixel counter = 0
  - tag counter = 0; tag FIFO empty; frames_loaded = 0
  - protocol_error = 0; classifier_input_read_data_a = 0
  - pixel_ready = 0 during reset
- Bank memory contents are not cleared.
- Per-bank state, 2-bit: EMPTY, FILLING, FULL.
- Fill side:
  - pixel_ready = !reset && state[wr_bank] != FULL.
  - On pixel_valid && pixel_ready: write mem[wr_bank][cnt] and increment cnt; bank goes EMPTY->FILLING on the first pixel.
  - On the pixel with cnt == PIXELS-1: bank -> FULL, cnt -> 0, wr_bank toggles, frames_loaded increments (wraps at 2^TAG_W).
  - When both banks are FULL, pixel_ready = 0 until a release.
- Read side:
  - input_valid = state[rd_bank] == FULL && tag FIFO not full, combinational.
  - classifier_input_read_data_a <= {8'b0, mem[rd_bank][addr]} at every clock edge; this is a registered read.
  - addr >= PIXELS returns 16'h0000.
- Release:
  - Valid release: write_en with write_data[0] == 0 while input_valid == 1.
  - Effect: state[rd_bank] -> EMPTY; rd_bank toggles; push tag counter into the tag FIFO; tag counter increments (wraps).
  - write_en with write_data[0] == 1 is a no-op.
  - write_en with write_data[0] == 0 while input_valid == 0 is ignored and sets protocol_error.
- Simultaneous fill-complete and release on different banks in the same cycle: both take effect.
- Release of bank X and first pixel into bank X in the same cycle cannot occur: pixel_ready was low because X was FULL. The write lands next cycle.
- Result side, combinational pass-through:
  - result_valid = classifier_output_valid && tag FIFO not empty
  - classifier_output_ready = result_ready && tag FIFO not empty
  - result_data = classifier_output; result_tag = FIFO head
  - Pop the FIFO on classifier_output_valid && classifier_output_ready.
- Prediction arriving with the tag FIFO empty: stalls (ready = 0) and sets protocol_error.
- Push and pop of the tag FIFO in the same cycle are both honored; occupancy is unchanged.
- Reset mid-frame: a partial fill is discarded, the frame in the classifier is abandoned, and pending tags are lost.

Test Plan:
- Stream frame A (784 pixels, value = index[7:0]) -> pixel_ready stays 1; read_data_b01 = 16'h0000 before the final pixel. After the final pixel: frames_loaded = 1, input_valid read = 8'h01, address 5 returns 16'h0005 one cycle later.
- Stream frames A, B, C back-to-back with no release -> pixel_ready drops to 0 after pixel 1567 (end of B); frames_loaded = 2. Release (write_en, data 0) -> pixel_ready = 1 the next cycle, input_valid stays 1 (bank 1 FULL), and address reads now return frame B.
- Release A, then classifier_output = 4'd7 valid with result_ready = 1 -> result_data = 7, result_tag = 0. Repeat for B with output 3 -> tag = 1.
- Four releases with classifier_output_valid held 0 -> tag FIFO full; input_valid reads 8'h00 even with a FULL bank. One prediction accepted -> input_valid returns to 1.
- write_en with data 0 when no bank is FULL -> state unchanged, protocol_error = 1. Write_en with data 8'h01 on a FULL bank -> no release, error unchanged.
- Reset asserted after 400 pixels of a frame -> next cycle frames_loaded = 0, input_valid = 0, protocol_error = 0. A fresh 784-pixel frame then loads into bank 0 correctly.
